// File: rtl/disparity_wta_sequencer.sv
// Winner-take-all sequencer for the SGM disparity stage.
// Accepts one NDISP-wide aggregated-cost vector, sweeps it CHUNK costs per
// cycle through a single shared min-index tree, and emits the minimum cost
// together with its disparity. The lowest disparity wins every tie.
module disparity_wta_sequencer #(
  parameter int DATA_DEPTH = 8,
  parameter int NDISP      = 64,
  parameter int CHUNK      = 16,
  parameter int IDX_W      = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_DEPTH*NDISP-1:0] in_cost,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_DEPTH-1:0]       out_min,
  output logic [IDX_W-1:0]            out_idx,
  output logic                        busy
);

  localparam int NCHUNK     = NDISP / CHUNK;
  localparam int CNT_W      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int LIDX_W     = $clog2(CHUNK);
  localparam int CHUNK_BITS = CHUNK * DATA_DEPTH;

  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                  state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        out_valid_q, out_valid_d;
  logic [DATA_DEPTH-1:0]       out_min_q, out_min_d;
  logic [IDX_W-1:0]            out_idx_q, out_idx_d;
  logic [DATA_DEPTH*NDISP-1:0] buf_q;
  logic [DATA_DEPTH-1:0]       run_min_q;
  logic [IDX_W-1:0]            run_idx_q;
  logic                        load_buf;

  logic [CHUNK_BITS-1:0]       chunk_costs;
  logic [DATA_DEPTH-1:0]       tree_min;
  logic [LIDX_W-1:0]           tree_idx;
  logic [IDX_W-1:0]            chunk_abs_idx;
  logic                        take_chunk;
  logic [DATA_DEPTH-1:0]       best_min;
  logic [IDX_W-1:0]            best_idx;

  // Select the chunk addressed by the counter from the captured vector.
  assign chunk_costs = buf_q[cnt_q*CHUNK_BITS +: CHUNK_BITS];

  // Binary min-index reduction over one chunk; the upper operand of each
  // node wins only when strictly smaller, so the lowest index wins ties.
  always_comb begin : min_tree
    logic [DATA_DEPTH-1:0] m  [CHUNK];
    logic [LIDX_W-1:0]     ix [CHUNK];
    // NOTE: blocking assignments here build a combinational chain evaluated
    // in order; every level fully overwrites the entries it produces.
    for (int i = 0; i < CHUNK; i++) begin
      m[i]  = chunk_costs[i*DATA_DEPTH +: DATA_DEPTH];
      ix[i] = LIDX_W'(i);
    end
    for (int w = CHUNK / 2; w >= 1; w = w / 2) begin
      for (int j = 0; j < w; j++) begin
        if (m[2*j+1] < m[2*j]) begin
          m[j]  = m[2*j+1];
          ix[j] = ix[2*j+1];
        end else begin
          m[j]  = m[2*j];
          ix[j] = ix[2*j];
        end
      end
    end
    tree_min = m[0];
    tree_idx = ix[0];
  end

  // Merge the chunk winner into the running minimum; earlier chunks keep
  // the win on equal cost because the replacement test is strict.
  always_comb begin
    chunk_abs_idx = (IDX_W'(cnt_q) << LIDX_W) | IDX_W'(tree_idx);
    take_chunk    = (cnt_q == '0) || (tree_min < run_min_q);
    best_min      = take_chunk ? tree_min      : run_min_q;
    best_idx      = take_chunk ? chunk_abs_idx : run_idx_q;
  end

  // Next-state logic for the IDLE -> SCAN -> DONE sequence.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_min_d   = out_min_q;
    out_idx_d   = out_idx_q;
    load_buf    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load_buf = 1'b1;
          cnt_d    = '0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CHUNK) begin
          cnt_d       = '0;
          out_min_d   = best_min;
          out_idx_d   = best_idx;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_min_q   <= '0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_min_q   <= out_min_d;
      out_idx_q   <= out_idx_d;
    end
  end

  // Vector buffer and running minimum; both are written before being read
  // in every transaction.
  always_ff @(posedge clk) begin
    // NOTE: the wide buffer is deliberately left without reset; its contents
    // are only consumed after a fresh accept has overwritten them.
    if (load_buf) begin
      buf_q <= in_cost;
    end
    if (state_q == SCAN) begin
      run_min_q <= best_min;
      run_idx_q <= best_idx;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_min   = out_min_q;
  assign out_idx   = out_idx_q;

endmodule
